// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port plus decode-side control and results.
// master = fetch stage, slave = the memory/decode side that surrounds it.
interface instruction_fetch_if #(
    parameter int unsigned DWIDTH = 32
);
    logic              stall;
    logic              redirect;
    logic [DWIDTH-1:0] redirectTarget;
    logic [DWIDTH-1:0] instructionIn;
    logic              imemEnable;
    logic [DWIDTH-1:0] imemAddress;
    logic [DWIDTH-1:0] instructionOut;
    logic [DWIDTH-1:0] pcOut;
    logic              valid;

    modport master (
        input  stall, redirect, redirectTarget, instructionIn,
        output imemEnable, imemAddress, instructionOut, pcOut, valid
    );

    modport slave (
        output stall, redirect, redirectTarget, instructionIn,
        input  imemEnable, imemAddress, instructionOut, pcOut, valid
    );
endinterface

// File: rtl/instruction_fetch.sv
// PC / fetch-control stage ahead of a synchronous-read instruction memory.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect sets sticky misaligned and halts.
module instruction_fetch #(
    parameter int unsigned       DWIDTH   = 32,
    parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master fif,
    output logic [31:0]         fetchCount,
    output logic                misaligned
);
    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

    state_t            state, state_next;
    logic [DWIDTH-1:0] pc, pc_next;
    logic [DWIDTH-1:0] fetch_pc, fetch_pc_next;
    logic              valid_q, valid_next;
    logic [31:0]       count_q, count_next;
    logic              mis_q, mis_next;
    logic              trap;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign trap = (fif.redirectTarget[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            pc       <= RESET_PC;
            fetch_pc <= RESET_PC;
            valid_q  <= 1'b0;
            count_q  <= '0;
            mis_q    <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            fetch_pc <= fetch_pc_next;
            valid_q  <= valid_next;
            count_q  <= count_next;
            mis_q    <= mis_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        fetch_pc_next = fetch_pc;
        valid_next    = valid_q;
        count_next    = count_q;
        mis_next      = mis_q;
        if (state == HALT) begin
            valid_next = 1'b0;
        end else if (fif.redirect) begin
            valid_next = 1'b0;
            if (trap) begin
                mis_next   = 1'b1;
                state_next = HALT;
            end else begin
                pc_next    = {fif.redirectTarget[DWIDTH-1:2], 2'b00};
                state_next = RUN;
            end
        end else if (fif.stall) begin
            state_next = STALL;
        end else begin
            fetch_pc_next = pc;
            pc_next       = pc + DWIDTH'(4);
            valid_next    = 1'b1;
            count_next    = count_q + 32'd1;
            state_next    = RUN;
        end
    end

    // STALL behaves like RUN once stall drops: leaving it performs the advance, so the
    // memory must be enabled on that same cycle.
    assign fif.imemEnable     = !reset && (state != HALT) && !fif.stall && !fif.redirect;
    assign fif.imemAddress    = pc;
    assign fif.instructionOut = fif.instructionIn;
    assign fif.pcOut          = fetch_pc;
    assign fif.valid          = valid_q;
    assign fetchCount         = count_q;
    assign misaligned         = mis_q;
endmodule
